// File: rtl/debounce_filter_if.sv
// Debounce filter signal bundle: raw level and clear in, filtered level,
// strobes and transition count out.
interface debounce_filter_if #(
    parameter int EVT_W = 16
);
    logic             din;
    logic             clr;
    logic             dout;
    logic             rise;
    logic             fall;
    logic             busy;
    logic [EVT_W-1:0] evt_count;

    modport master (output din, clr, input dout, rise, fall, busy, evt_count);
    modport slave  (input din, clr, output dout, rise, fall, busy, evt_count);
endinterface

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a 4-state qualifier. A new level is accepted
// only after STABLE_CYCLES consecutive synchronised samples agree.
module debounce_filter #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8,
    parameter int EVT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    debounce_filter_if.slave bus
);
    localparam logic [1:0] LOW   = 2'd0;
    localparam logic [1:0] CHK_H = 2'd1;
    localparam logic [1:0] HIGH  = 2'd2;
    localparam logic [1:0] CHK_L = 2'd3;

    // counter holds samples already qualified, so the last one is STABLE_CYCLES-1
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             s1, s;
    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             acc_rise, acc_fall;
    logic             rise_q, fall_q;
    logic [EVT_W-1:0] evt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= bus.din;
            s  <= s1;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            LOW: begin
                if (s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_nx = HIGH;
                    end else begin
                        state_nx = CHK_H;
                        cnt_nx   = ONE;
                    end
                end
            end
            CHK_H: begin
                if (!s) begin
                    state_nx = LOW;
                    cnt_nx   = '0;
                end else if (cnt == LAST) begin
                    state_nx = HIGH;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            HIGH: begin
                if (!s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_nx = LOW;
                    end else begin
                        state_nx = CHK_L;
                        cnt_nx   = ONE;
                    end
                end
            end
            CHK_L: begin
                if (s) begin
                    state_nx = HIGH;
                    cnt_nx   = '0;
                end else if (cnt == LAST) begin
                    state_nx = LOW;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            default: begin
                state_nx = LOW;
                cnt_nx   = '0;
            end
        endcase
    end

    // an accepted transition is any move between the low side and the high side
    assign acc_rise = (state == LOW  || state == CHK_H) && (state_nx == HIGH);
    assign acc_fall = (state == HIGH || state == CHK_L) && (state_nx == LOW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LOW;
            cnt    <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            rise_q <= acc_rise;
            fall_q <= acc_fall;
        end
    end

    // clear wins over a coincident transition; count saturates at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q <= '0;
        end else if (bus.clr) begin
            evt_q <= '0;
        end else if ((acc_rise || acc_fall) && (evt_q != {EVT_W{1'b1}})) begin
            evt_q <= evt_q + {{(EVT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.dout      = (state == HIGH)  || (state == CHK_L);
    assign bus.busy      = (state == CHK_H) || (state == CHK_L);
    assign bus.rise      = rise_q;
    assign bus.fall      = fall_q;
    assign bus.evt_count = evt_q;
endmodule

// File: tb/tb_debounce_filter.sv
// Directed plus randomised bench for debounce_filter; two instances (16-bit and
// 2-bit event counters) share the stimulus and are checked against a run-length model.
module tb_debounce_filter;
    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    debounce_filter_if #(.EVT_W(16)) b16 ();
    debounce_filter_if #(.EVT_W(2))  b2 ();

    assign b16.din = din;
    assign b16.clr = clr;
    assign b2.din  = din;
    assign b2.clr  = clr;

    debounce_filter #(.STABLE_CYCLES(SC), .CNT_W(8), .EVT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b16));
    debounce_filter #(.STABLE_CYCLES(SC), .CNT_W(8), .EVT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2));

    // Reference: count how long the synchronised sample has held its value;
    // a sample that differs from the output and has held SC times is accepted.
    logic        m_s1, m_s, m_last, m_dout, m_rise, m_fall;
    int          m_streak;
    logic [15:0] m_evt;
    logic [1:0]  m_evt2;
    int          st;
    logic        acc, m_busy;

    assign st     = (m_s == m_last) ? m_streak + 1 : 1;
    assign acc    = (m_s != m_dout) && (st >= SC);
    assign m_busy = (m_last != m_dout);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= 0; m_s <= 0; m_last <= 0; m_streak <= 0;
            m_dout <= 0; m_rise <= 0; m_fall <= 0; m_evt <= 0; m_evt2 <= 0;
        end else begin
            m_s1     <= din;
            m_s      <= m_s1;
            m_last   <= m_s;
            m_streak <= st;
            if (acc) m_dout <= m_s;
            m_rise   <= acc && m_s;
            m_fall   <= acc && !m_s;
            m_evt    <= clr ? 16'd0 : (acc && m_evt != 16'hFFFF) ? m_evt + 16'd1 : m_evt;
            m_evt2   <= clr ? 2'd0 : (acc && m_evt2 != 2'd3) ? m_evt2 + 2'd1 : m_evt2;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".dout"}, 32'(b16.dout), 32'(m_dout));
        chk({tag, ".rise"}, 32'(b16.rise), 32'(m_rise));
        chk({tag, ".fall"}, 32'(b16.fall), 32'(m_fall));
        chk({tag, ".busy"}, 32'(b16.busy), 32'(m_busy));
        chk({tag, ".evt"},  32'(b16.evt_count), 32'(m_evt));
        chk({tag, ".dout2"}, 32'(b2.dout), 32'(m_dout));
        chk({tag, ".evt2"}, 32'(b2.evt_count), 32'(m_evt2));
        chk({tag, ".excl"}, 32'(b16.rise && b16.fall), 32'd0);
    endtask

    task automatic cyc(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            chk_model(tag);
        end
    endtask

    initial begin
        int  rises, falls, hold;
        logic busy_seen;

        // reset held with din high
        rst_n = 1'b0; din = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.dout", 32'(b16.dout), 0);
        chk("rst.rise", 32'(b16.rise), 0);
        chk("rst.fall", 32'(b16.fall), 0);
        chk("rst.busy", 32'(b16.busy), 0);
        chk("rst.evt",  32'(b16.evt_count), 0);
        din = 1'b0; rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("idle.dout", 32'(b16.dout), 0);
            chk("idle.busy", 32'(b16.busy), 0);
            chk_model("idle");
        end

        // rising edge latency
        din = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("rise.busy@%0d", k), 32'(b16.busy), 32'(k >= 3 && k < 6));
            chk($sformatf("rise.dout@%0d", k), 32'(b16.dout), 32'(k >= 6));
            chk($sformatf("rise.rise@%0d", k), 32'(b16.rise), 32'(k == 6));
            chk_model("rise");
        end
        chk("rise.evt", 32'(b16.evt_count), 1);

        // falling edge latency
        din = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("fall.dout@%0d", k), 32'(b16.dout), 32'(k < 6));
            chk($sformatf("fall.fall@%0d", k), 32'(b16.fall), 32'(k == 6));
            chk_model("fall");
        end
        chk("fall.evt", 32'(b16.evt_count), 2);

        // glitch in LOW
        busy_seen = 1'b0;
        din = 1'b1;
        for (int k = 0; k < 13; k++) begin
            if (k == 3) din = 1'b0;
            @(negedge clk);
            busy_seen |= b16.busy;
            chk("glitchL.dout", 32'(b16.dout), 0);
            chk_model("glitchL");
        end
        chk("glitchL.busy_seen", 32'(busy_seen), 1);
        chk("glitchL.busy_end", 32'(b16.busy), 0);
        chk("glitchL.evt", 32'(b16.evt_count), 2);

        din = 1'b1;
        cyc(8, "toH");
        chk("toH.dout", 32'(b16.dout), 1);

        // glitch in HIGH
        busy_seen = 1'b0;
        din = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (k == 3) din = 1'b1;
            @(negedge clk);
            busy_seen |= b16.busy;
            chk("glitchH.dout", 32'(b16.dout), 1);
            chk_model("glitchH");
        end
        chk("glitchH.busy_seen", 32'(busy_seen), 1);
        chk("glitchH.evt", 32'(b16.evt_count), 3);

        // alternating toggles
        rises = 0; falls = 0;
        for (int i = 0; i < 6; i++) begin
            din = ~din;
            repeat (10) begin
                @(negedge clk);
                rises += int'(b16.rise);
                falls += int'(b16.fall);
                chk_model("toggle");
            end
        end
        chk("toggle.rises", 32'(rises), 3);
        chk("toggle.falls", 32'(falls), 3);
        chk("toggle.evt", 32'(b16.evt_count), 9);

        // saturation of the 2-bit counter, then clear vs transition
        rst_n = 1'b0; din = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            din = ~din;
            cyc(10, "sat");
            chk($sformatf("sat.evt2@%0d", i), 32'(b2.evt_count), 32'((i < 3) ? i : 3));
        end
        din = ~din;
        cyc(5, "clrx");
        clr = 1'b1;
        @(negedge clk);
        chk("clrx.evt2", 32'(b2.evt_count), 0);
        chk("clrx.evt", 32'(b16.evt_count), 0);
        chk("clrx.fall", 32'(b16.fall), 1);
        chk_model("clrx");
        clr = 1'b0;

        // asynchronous reset mid-qualification
        din = 1'b1; cyc(10, "pre6");
        din = 1'b0; cyc(10, "pre6");
        din = 1'b1;
        cyc(4, "chkh");
        chk("chkh.busy", 32'(b16.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.dout", 32'(b16.dout), 0);
        chk("arst.busy", 32'(b16.busy), 0);
        chk("arst.evt",  32'(b16.evt_count), 0);
        chk("arst.evt2", 32'(b2.evt_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("rel.dout@%0d", k), 32'(b16.dout), 32'(k >= SC + 2));
            chk_model("rel");
        end

        // randomised bounce
        for (int seg = 0; seg < 60; seg++) begin
            din  = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(1, 8));
            for (int c = 0; c < hold; c++) begin
                clr = ($urandom_range(0, 15) == 0);
                cyc(1, "rand");
            end
        end
        clr = 1'b0;
        cyc(10, "drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
